// File: rtl/seqgen_pkg.sv
// ============================================================================
// Module      : seqgen_pkg
// Description : Shared types and defaults for the serial pattern transmitter.
//               The optional parity feature is controlled by SEQGEN_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seqgen_pkg;

    localparam int         DEF_PAT_W = 5;
    localparam int         DEF_CNT_W = 4;
    localparam logic [4:0] PAT_10010 = 5'b10010;

    // One-hot so that any multi-bit or zero value is recognisably illegal
    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        SHIFT = 4'b0010,
        PAR   = 4'b0100,
        DONE  = 4'b1000
    } state_t;

endpackage

`default_nettype wire

// File: rtl/seqgen_10010_tx_if.sv
// ============================================================================
// Module      : seqgen_10010_tx_if
// Description : Start/ready request channel and serial output of the pattern
//               transmitter. master = requester/observer, slave = transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seqgen_10010_tx_if
    import seqgen_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    parameter int CNT_W = DEF_CNT_W
) ();

    logic             start_i;
    logic [PAT_W-1:0] pat_i;
    logic [CNT_W-1:0] rep_i;
    logic             rdy_o;
    logic             aout;
    logic             vld_o;
    logic             done_o;

    modport master (
        output start_i, pat_i, rep_i,
        input  rdy_o, aout, vld_o, done_o
    );

    modport slave (
        input  start_i, pat_i, rep_i,
        output rdy_o, aout, vld_o, done_o
    );

endinterface

`default_nettype wire

// File: rtl/seqgen_10010_tx_piso.sv
// ============================================================================
// Module      : seqgen_piso
// Description : Parallel-in/serial-out shift register holding the working
//               pattern plus a captured copy used to restart each repeat.
//               With SEQGEN_PARITY_EN, also provides even parity of the copy.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seqgen_piso
    import seqgen_pkg::*;
#(
    parameter int               PAT_W   = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PAT_DEF = PAT_W'(PAT_10010)
) (
    input  wire logic             clk,
    input  wire logic             nrst,
    input  wire logic             load_i,
    input  wire logic [PAT_W-1:0] pat_i,
    input  wire logic             shift_i,
    input  wire logic             reload_i,
`ifdef SEQGEN_PARITY_EN
    output      logic             par_o,
`endif
    output      logic             msb_o
);

    logic [PAT_W-1:0] shreg_q, shreg_d;
    logic [PAT_W-1:0] copy_q,  copy_d;

    // Load wins over reload, reload wins over shift (last bit of a copy)
    always_comb begin
        shreg_d = shreg_q;
        copy_d  = copy_q;
        if (load_i) begin
            shreg_d = pat_i;
            copy_d  = pat_i;
        end else if (reload_i) begin
            shreg_d = copy_q;
        end else if (shift_i) begin
            shreg_d = {shreg_q[PAT_W-2:0], 1'b0};
        end
    end

    // Pattern and captured-copy registers
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            shreg_q <= PAT_DEF;
            copy_q  <= PAT_DEF;
        end else begin
            shreg_q <= shreg_d;
            copy_q  <= copy_d;
        end
    end

    assign msb_o = shreg_q[PAT_W-1];
`ifdef SEQGEN_PARITY_EN
    assign par_o = ^copy_q;
`endif

endmodule

`default_nettype wire

// File: rtl/seqgen_10010_tx.sv
// ============================================================================
// Module      : seqgen_10010_tx
// Description : Serial pattern transmitter. Captures a pattern and repeat
//               count on start/ready, then sends rep+1 back-to-back copies
//               MSB-first on aout. Define SEQGEN_PARITY_EN to append an
//               even-parity bit after every copy.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seqgen_10010_tx
    import seqgen_pkg::*;
#(
    parameter int               PAT_W   = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PAT_DEF = PAT_W'(PAT_10010),
    parameter int               CNT_W   = DEF_CNT_W
) (
    input wire logic       clk,
    input wire logic       nrst,
    seqgen_10010_tx_if.slave bus
);

    localparam int             BC_W    = $clog2(PAT_W);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(PAT_W - 1);

    state_t           state_q, state_d;
    logic [BC_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;

    logic w_load, w_shift, w_reload, w_msb;
    logic w_aout, w_vld, w_rdy, w_done;
`ifdef SEQGEN_PARITY_EN
    logic w_par;
`endif

    seqgen_piso #(
        .PAT_W   (PAT_W),
        .PAT_DEF (PAT_DEF)
    ) u_piso (
        .clk      (clk),
        .nrst     (nrst),
        .load_i   (w_load),
        .pat_i    (bus.pat_i),
        .shift_i  (w_shift),
        .reload_i (w_reload),
`ifdef SEQGEN_PARITY_EN
        .par_o    (w_par),
`endif
        .msb_o    (w_msb)
    );

    // Next-state, counter and Moore output decode
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rep_cnt_d = rep_cnt_q;
        w_load    = 1'b0;
        w_shift   = 1'b0;
        w_reload  = 1'b0;
        w_aout    = 1'b0;
        w_vld     = 1'b0;
        w_rdy     = 1'b0;
        w_done    = 1'b0;
        case (state_q)
            IDLE: begin
                w_rdy = 1'b1;
                if (bus.start_i) begin
                    w_load    = 1'b1;
                    rep_cnt_d = bus.rep_i;
                    bit_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                w_vld     = 1'b1;
                w_aout    = w_msb;
                w_shift   = 1'b1;
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == BC_LAST) begin
                    bit_cnt_d = '0;
`ifdef SEQGEN_PARITY_EN
                    state_d = PAR;
`else
                    // Reload now so the next copy follows with no idle bit
                    w_reload = 1'b1;
                    if (rep_cnt_q != '0) begin
                        rep_cnt_d = rep_cnt_q - 1'b1;
                    end else begin
                        state_d = DONE;
                    end
`endif
                end
            end
`ifdef SEQGEN_PARITY_EN
            PAR: begin
                w_vld    = 1'b1;
                w_aout   = w_par;
                w_reload = 1'b1;
                if (rep_cnt_q != '0) begin
                    rep_cnt_d = rep_cnt_q - 1'b1;
                    state_d   = SHIFT;
                end else begin
                    state_d = DONE;
                end
            end
`endif
            DONE: begin
                w_done = 1'b1;
                w_rdy  = 1'b1;
                if (bus.start_i) begin
                    w_load    = 1'b1;
                    rep_cnt_d = bus.rep_i;
                    bit_cnt_d = '0;
                    state_d   = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                // Illegal encoding: present reset-value outputs, recover to IDLE
                w_rdy     = 1'b1;
                bit_cnt_d = '0;
                rep_cnt_d = '0;
                state_d   = IDLE;
            end
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            rep_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            rep_cnt_q <= rep_cnt_d;
        end
    end

    assign bus.aout   = w_aout;
    assign bus.vld_o  = w_vld;
    assign bus.rdy_o  = w_rdy;
    assign bus.done_o = w_done;

endmodule

`default_nettype wire

// File: tb/tb_seqgen_10010_tx.sv
// ============================================================================
// Module      : tb_seqgen_10010_tx
// Description : Self-checking bench for seqgen_10010_tx: directed vector table,
//               hand-written corner sequences and randomized traffic against a
//               stream-level reference model. Honours SEQGEN_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seqgen_10010_tx;

    localparam int PAT_W = 5;
    localparam int CNT_W = 4;
`ifdef SEQGEN_PARITY_EN
    localparam int COPY_LEN = PAT_W + 1;
`else
    localparam int COPY_LEN = PAT_W;
`endif

    // {aout, vld_o, rdy_o, done_o}
    localparam logic [3:0] EXP_IDLE = 4'b0010;
    localparam logic [3:0] EXP_DONE = 4'b0011;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    seqgen_10010_tx_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus ();

    seqgen_10010_tx #(
        .PAT_W   (PAT_W),
        .PAT_DEF (5'b10010),
        .CNT_W   (CNT_W)
    ) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] dut_out();
        return {bus.aout, bus.vld_o, bus.rdy_o, bus.done_o};
    endfunction

    task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got {aout,vld,rdy,done}=%b expected %b", name, $time, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: every accepted request expands into the complete
    // list of per-cycle outputs it must produce; idle when list is empty.
    // ------------------------------------------------------------------
    logic [3:0] exp_q[$];
    logic [3:0] cur = EXP_IDLE;

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            exp_q.delete();
            cur = EXP_IDLE;
        end else begin
            if (cur[1] && bus.start_i) begin
                for (int c = 0; c <= int'(bus.rep_i); c++) begin
                    for (int b = PAT_W - 1; b >= 0; b--)
                        exp_q.push_back({bus.pat_i[b], 3'b100});
`ifdef SEQGEN_PARITY_EN
                    exp_q.push_back({^bus.pat_i, 3'b100});
`endif
                end
                exp_q.push_back(EXP_DONE);
            end
            if (exp_q.size() > 0) cur = exp_q.pop_front();
            else                  cur = EXP_IDLE;
        end
    end

    always @(negedge clk) chk("model", dut_out(), cur);

    // ------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic [4:0]  pat;
        logic [3:0]  rep;
        int          len;
        logic [63:0] bits;   // right-aligned, first bit at index len-1
        int          occ;    // overlapping 10010 occurrences in the stream
    } vec_t;

    vec_t vecs[5];

    task automatic run_vec(input vec_t v);
        logic [4:0] win;
        int         occ;
        win = '0;
        occ = 0;
        bus.start_i = 1'b1;
        bus.pat_i   = v.pat;
        bus.rep_i   = v.rep;
        @(negedge clk);
        // Request is captured; later input changes must not matter
        bus.start_i = 1'b0;
        bus.pat_i   = ~v.pat;
        bus.rep_i   = 4'hF;
        for (int k = 0; k < v.len; k++) begin
            chk("vec_bit", dut_out(), {v.bits[v.len-1-k], 3'b100});
            win = {win[3:0], bus.aout};
            if (k >= 4 && win == 5'b10010) occ++;
            @(negedge clk);
        end
        chk("vec_done", dut_out(), EXP_DONE);
        n_tests++;
        if (occ != v.occ) begin
            n_fail++;
            $display("FAIL vec_occ: got %0d occurrences expected %0d", occ, v.occ);
        end
        @(negedge clk);
        chk("vec_idle", dut_out(), EXP_IDLE);
    endtask

    initial begin
`ifdef SEQGEN_PARITY_EN
        vecs[0] = '{5'b10010, 4'd0, 6,  64'b100100,        1};
        vecs[1] = '{5'b10110, 4'd0, 6,  64'b101101,        0};
        vecs[2] = '{5'b10010, 4'd1, 12, 64'b100100100100,  3};
        vecs[3] = '{5'b11001, 4'd0, 6,  64'b110011,        0};
        vecs[4] = '{5'b01111, 4'd0, 6,  64'b011110,        0};
`else
        vecs[0] = '{5'b10010, 4'd0, 5,  64'b10010,           1};
        vecs[1] = '{5'b10010, 4'd2, 15, 64'b100101001010010, 3};
        vecs[2] = '{5'b11001, 4'd0, 5,  64'b11001,           0};
        vecs[3] = '{5'b10110, 4'd1, 10, 64'b1011010110,      0};
        vecs[4] = '{5'b01111, 4'd0, 5,  64'b01111,           0};
`endif
        bus.start_i = 1'b0;
        bus.pat_i   = '0;
        bus.rep_i   = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_outputs", dut_out(), EXP_IDLE);
        nrst = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_after_reset", dut_out(), EXP_IDLE);

        // Table
        foreach (vecs[i]) run_vec(vecs[i]);

        // start_i held high: restarts only from DONE, one idle gap per stream
        bus.start_i = 1'b1;
        bus.pat_i   = 5'b10010;
        bus.rep_i   = 4'd0;
        for (int k = 0; k < 4 * (COPY_LEN + 1); k++) begin
            @(negedge clk);
            chk("held_start", dut_out(),
                ((k % (COPY_LEN + 1)) == COPY_LEN) ? EXP_DONE
                                                   : {bus.pat_i[PAT_W-1-(k % (COPY_LEN+1)) % PAT_W] & ((k % (COPY_LEN+1)) < PAT_W)
                                                      | (((k % (COPY_LEN+1)) >= PAT_W) & (^bus.pat_i)), 3'b100});
        end
        bus.start_i = 1'b0;
        repeat (COPY_LEN + 3) @(negedge clk);
        chk("held_start_drained", dut_out(), EXP_IDLE);

        // Asynchronous reset during bit 3 of a rep_i=3 stream
        bus.start_i = 1'b1;
        bus.pat_i   = 5'b10010;
        bus.rep_i   = 4'd3;
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("bit3_before_reset", dut_out(), 4'b0100);
        #2 nrst = 1'b0;
        #1 chk("async_clear", dut_out(), EXP_IDLE);
        @(negedge clk);
        #2 nrst = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.pat_i   = 5'b11001;
        bus.rep_i   = 4'd0;
        @(negedge clk);
        bus.start_i = 1'b0;
        for (int k = 0; k < PAT_W; k++) begin
            chk("fresh_after_reset", dut_out(), {5'b11001 >> (PAT_W-1-k) & 5'b1, 3'b100} & 4'b1111);
            @(negedge clk);
        end
        repeat (COPY_LEN + 2) @(negedge clk);

        // Randomized traffic, checked every cycle by the model
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            bus.start_i = ($urandom_range(0, 2) == 0);
            bus.pat_i   = PAT_W'($urandom);
            bus.rep_i   = ($urandom_range(0, 7) == 0) ? CNT_W'($urandom) : CNT_W'($urandom_range(0, 2));
            if ($urandom_range(0, 149) == 0) begin
                #2 nrst = 1'b0;
                @(negedge clk);
                #2 nrst = 1'b1;
            end
        end
        bus.start_i = 1'b0;
        repeat ((1 << CNT_W) * COPY_LEN + 4) @(negedge clk);
        chk("final_idle", dut_out(), EXP_IDLE);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
